result_checker: RTL and testbench

- Self-checking sink that sits directly downstream of the `arf` dataflow graph's `out` operator, in place of the plain consumer.
- Drives the req/ack pull handshake of the `dout_*` port and captures each result word.
- Compares each word against an affine golden model, expected(i) = scale*i + offset. For the default graph this is 3*i+2.
- Stalls req pseudo-randomly from an LFSR, keeps error and cycle statistics, and raises done/pass for the bench to report.

---
 rtl/result_checker_if.sv | 12 +
 rtl/result_checker.sv | 110 +++++++++++
 tb/tb_result_checker.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/result_checker_if.sv
// rtl/result_checker_if.sv - req/ack pull handshake between the out operator and its consumer
interface result_checker_if #(
  parameter int data_width = 32
);
  logic                  req;
  logic                  ack;
  logic [data_width-1:0] din;

  // master: the consumer that pulls words; slave: the upstream out operator
  modport master (output req, input ack, input din);
  modport slave  (input req, output ack, output din);
endinterface

// File: rtl/result_checker.sv
// rtl/result_checker.sv - self-checking sink comparing pulled words against scale*i + offset
module result_checker #(
  parameter int          data_width      = 32,
  parameter int          scale           = 3,
  parameter int          offset          = 2,
  parameter int          start_index     = 0,
  parameter int          max_count       = 5000,
  parameter int          stall_threshold = 0,
  parameter logic [15:0] lfsr_seed       = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  result_checker_if.master        dout,
  output logic [31:0]             count,
  output logic [31:0]             err_count,
  output logic [31:0]             first_err_idx,
  output logic [data_width-1:0]   first_err_data,
  output logic                    proto_err,
  output logic [31:0]             cycle_count,
  output logic                    done,
  output logic                    pass
);
  typedef enum logic {RUN, DONE} state_t;

  localparam logic [data_width-1:0] exp_init = data_width'(scale * start_index + offset);
  localparam logic [data_width-1:0] scale_w  = data_width'(scale);
  localparam logic [8:0]            thr      = 9'(stall_threshold);
  localparam logic [31:0]           max_cnt  = 32'(max_count);

  state_t                state_q, state_d;
  logic [15:0]           lfsr_q;
  logic                  lfsr_fb;
  logic                  req_q;
  logic                  req_d_q;
  logic [data_width-1:0] exp_q;
  logic                  accept;
  logic                  last;
  logic                  mismatch;
  logic                  stall;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign stall    = {1'b0, lfsr_q[7:0]} < thr;
  assign mismatch = accept && (dout.din != exp_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // last covers both the final accept and the degenerate max_count == 0 case
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      RUN: begin
        accept = dout.ack;
        last   = (max_cnt == 32'd0) || (accept && count == max_cnt - 32'd1);
        if (last) state_d = DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q         <= lfsr_seed;
      req_q          <= 1'b0;
      req_d_q        <= 1'b0;
      exp_q          <= exp_init;
      count          <= '0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
      proto_err      <= 1'b0;
      cycle_count    <= '0;
    end else begin
      lfsr_q  <= {lfsr_fb, lfsr_q[15:1]};
      req_d_q <= req_q;
      if (state_q == RUN) begin
        // req is held while unstalled; upstream gates on its own ack state
        req_q       <= last ? 1'b0 : ~stall;
        cycle_count <= sat_inc(cycle_count);
        if (dout.ack && !req_d_q) proto_err <= 1'b1;
        if (accept) begin
          count <= sat_inc(count);
          exp_q <= exp_q + scale_w;
          if (mismatch) begin
            err_count <= sat_inc(err_count);
            if (err_count == 32'd0) begin
              first_err_idx  <= count;
              first_err_data <= dout.din;
            end
          end
        end
      end else begin
        req_q <= 1'b0;
        if (dout.ack) proto_err <= 1'b1;
      end
    end
  end

  assign dout.req = req_q;
  assign done     = (state_q == DONE);
  assign pass     = done && (err_count == 32'd0) && !proto_err;
endmodule

// File: tb/tb_result_checker.sv
// tb/tb_result_checker.sv - randomized self-checking bench for result_checker
module tb_result_checker;
  localparam int max_a = 200;
  localparam int max_b = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  result_checker_if #(.data_width(32)) a_if ();
  result_checker_if #(.data_width(8))  b_if ();

  logic [31:0] count_a, err_a, fidx_a, cyc_a;
  logic [31:0] fdata_a;
  logic        proto_a, done_a, pass_a;
  logic [31:0] count_b, err_b, fidx_b, cyc_b;
  logic [7:0]  fdata_b;
  logic        proto_b, done_b, pass_b;

  result_checker #(
    .data_width(32), .scale(3), .offset(2), .start_index(0),
    .max_count(max_a), .stall_threshold(128), .lfsr_seed(16'hACE1)
  ) dut_a (
    .clk(clk), .rst(rst_a), .dout(a_if.master),
    .count(count_a), .err_count(err_a), .first_err_idx(fidx_a),
    .first_err_data(fdata_a), .proto_err(proto_a), .cycle_count(cyc_a),
    .done(done_a), .pass(pass_a)
  );

  result_checker #(
    .data_width(8), .scale(3), .offset(2), .start_index(84),
    .max_count(max_b), .stall_threshold(0), .lfsr_seed(16'hACE1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .dout(b_if.master),
    .count(count_b), .err_count(err_b), .first_err_idx(fidx_b),
    .first_err_data(fdata_b), .proto_err(proto_b), .cycle_count(cyc_b),
    .done(done_b), .pass(pass_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, want);
  endtask

  // reference model of the golden sequence and checker statistics for dut_a
  int          m_count, m_errs, m_first_idx, cyc, reqs;
  logic [31:0] m_first_data;
  bit          m_proto;

  function automatic logic [31:0] golden_a(input int i);
    return 32'(3 * i + 2);
  endfunction

  task automatic reset_a();
    rst_a = 1'b1;
    a_if.ack = 1'b0;
    a_if.din = '0;
    @(posedge clk); #1;
    rst_a = 1'b0;
    m_count = 0; m_errs = 0; m_first_idx = 0; m_first_data = '0; m_proto = 1'b0;
    check("rst_req",        64'(a_if.req), 64'(0));
    check("rst_count",      64'(count_a),  64'(0));
    check("rst_err_count",  64'(err_a),    64'(0));
    check("rst_first_idx",  64'(fidx_a),   64'(0));
    check("rst_first_data", 64'(fdata_a),  64'(0));
    check("rst_proto_err",  64'(proto_a),  64'(0));
    check("rst_cycle",      64'(cyc_a),    64'(0));
    check("rst_done",       64'(done_a),   64'(0));
    check("rst_pass",       64'(pass_a),   64'(0));
  endtask

  task automatic run_a(input int corrupt, input int reset_at, input bit force_first, input int ack_pct);
    bit          go;
    bit          req_prev = 1'b0;
    bit          did_reset = 1'b0;
    logic [31:0] word;
    int          guard = 0;
    cyc = 0;
    reqs = 0;
    while (m_count < max_a && guard < 20000) begin
      guard++;
      if (a_if.req) reqs++;
      go = (req_prev && ($urandom_range(99) < 32'(ack_pct))) || (force_first && cyc == 0);
      word = (m_count == corrupt) ? 32'd99 : golden_a(m_count);
      a_if.ack = go;
      a_if.din = go ? word : $urandom();
      if (go && !req_prev) m_proto = 1'b1;
      req_prev = a_if.req;
      @(posedge clk); #1;
      cyc++;
      if (go) begin
        if (word != golden_a(m_count)) begin
          if (m_errs == 0) begin
            m_first_idx  = m_count;
            m_first_data = word;
          end
          m_errs++;
        end
        m_count++;
      end
      check("count",     64'(count_a), 64'(m_count));
      check("err_count", 64'(err_a),   64'(m_errs));
      check("proto_err", 64'(proto_a), 64'(m_proto));
      check("done",      64'(done_a),  64'(m_count == max_a));
      if (go && !did_reset && m_count == reset_at) begin
        did_reset = 1'b1;
        reset_a();
        req_prev = 1'b0;
        cyc = 0;
        reqs = 0;
      end
    end
    a_if.ack = 1'b0;
    if (guard >= 20000) check("run_a_timeout", 64'(guard), 64'(0));
  endtask

  task automatic run_b();
    bit        go;
    bit        req_prev = 1'b0;
    logic [7:0] word;
    int        n = 0;
    int        c = 0;
    rst_b = 1'b1;
    b_if.ack = 1'b0;
    b_if.din = '0;
    @(posedge clk); #1;
    rst_b = 1'b0;
    check("b_rst_req",   64'(b_if.req), 64'(0));
    check("b_rst_count", 64'(count_b),  64'(0));
    while (n < max_b && c < 1000) begin
      if (c >= 1) check("b_req_high", 64'(b_if.req), 64'(1));
      go = req_prev;
      word = 8'(3 * (84 + n) + 2);
      b_if.ack = go;
      b_if.din = word;
      req_prev = b_if.req;
      @(posedge clk); #1;
      c++;
      if (go) n++;
      check("b_count",     64'(count_b), 64'(n));
      check("b_err_count", 64'(err_b),   64'(0));
    end
    b_if.ack = 1'b0;
    if (c >= 1000) check("run_b_timeout", 64'(c), 64'(0));
    check("b_done",      64'(done_b),  64'(1));
    check("b_pass",      64'(pass_b),  64'(1));
    check("b_proto_err", 64'(proto_b), 64'(0));
    check("b_cycle",     64'(cyc_b),   64'(c));
  endtask

  initial begin
    a_if.ack = 1'b0;
    a_if.din = '0;
    b_if.ack = 1'b0;
    b_if.din = '0;
    repeat (2) @(posedge clk);
    #1;

    // corrupted token 7, random ack gaps on top of the LFSR stalls
    reset_a();
    run_a(7, -1, 1'b0, 80);
    check("r1_err_count",  64'(err_a),   64'(m_errs));
    check("r1_first_idx",  64'(fidx_a),  64'(m_first_idx));
    check("r1_first_data", 64'(fdata_a), 64'(m_first_data));
    check("r1_pass",       64'(pass_a),  64'(0));
    check("r1_cycle",      64'(cyc_a),   64'(cyc));
    check("r1_req_frac",   64'((reqs * 100 >= cyc * 40) && (reqs * 100 <= cyc * 60)), 64'(1));
    repeat (5) @(posedge clk);
    #1;
    check("r1_req_after_done", 64'(a_if.req), 64'(0));
    check("r1_cycle_frozen",   64'(cyc_a),    64'(cyc));

    // clean source with a reset in the middle of the run
    reset_a();
    run_a(-1, 100, 1'b0, 100);
    check("r2_pass",      64'(pass_a),  64'(1));
    check("r2_err_count", 64'(err_a),   64'(0));
    check("r2_first_idx", 64'(fidx_a),  64'(0));
    check("r2_cycle",     64'(cyc_a),   64'(cyc));
    check("r2_proto_err", 64'(proto_a), 64'(0));

    // ack before any req, then once more after done
    reset_a();
    run_a(-1, -1, 1'b1, 70);
    check("r3_proto_err", 64'(proto_a), 64'(1));
    check("r3_err_count", 64'(err_a),   64'(0));
    a_if.ack = 1'b1;
    a_if.din = $urandom();
    @(posedge clk); #1;
    a_if.ack = 1'b0;
    check("r3_count_post_done", 64'(count_a), 64'(max_a));
    check("r3_err_post_done",   64'(err_a),   64'(0));
    check("r3_proto_post_done", 64'(proto_a), 64'(1));
    check("r3_pass",            64'(pass_a),  64'(0));

    // 8-bit datapath starting at index 84: 254, 1, 4, ...
    run_b();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
